// File: rtl/calc_arbiter_pkg.sv
// Shared types for the calculator arbiter: op codes, widths and FSM states.
package calc_pkg;

   localparam int CALC_OP_W  = 2;
   localparam int CALC_IN_W  = 16;
   localparam int CALC_OUT_W = 32;

   typedef enum logic [CALC_OP_W-1:0] {
      SUM = 2'd0,
      SUB = 2'd1,
      MUL = 2'd2,
      DIV = 2'd3
   } calc_op_e;

   typedef enum logic [1:0] {
      IDLE,
      EXEC,
      RESP
   } calc_arb_state_e;

endpackage

// File: rtl/calc_arbiter_if.sv
// Request/response and calculator bus of the arbiter, packed per requester.
interface calc_arbiter_if #(
   parameter int NUM_REQ = 4
);
   import calc_pkg::*;

   logic [NUM_REQ-1:0]           i_req_valid;
   logic [NUM_REQ-1:0]           o_req_ready;
   logic [CALC_OP_W*NUM_REQ-1:0] i_req_sel;
   logic [CALC_IN_W*NUM_REQ-1:0] i_req_a;
   logic [CALC_IN_W*NUM_REQ-1:0] i_req_b;
   logic [NUM_REQ-1:0]           o_rsp_valid;
   logic [NUM_REQ-1:0]           i_rsp_ready;
   logic [CALC_OUT_W-1:0]        o_rsp_data;
   logic                         o_rsp_err;
   logic [CALC_OP_W-1:0]         o_calc_sel;
   logic [CALC_IN_W-1:0]         o_calc_a;
   logic [CALC_IN_W-1:0]         o_calc_b;
   logic [CALC_OUT_W-1:0]        i_calc_r;
   logic                         o_busy;

   modport slave (
      input  i_req_valid, i_req_sel, i_req_a, i_req_b,
      input  i_rsp_ready, i_calc_r,
      output o_req_ready, o_rsp_valid, o_rsp_data, o_rsp_err,
      output o_calc_sel, o_calc_a, o_calc_b, o_busy
   );

   modport master (
      output i_req_valid, i_req_sel, i_req_a, i_req_b,
      output i_rsp_ready, i_calc_r,
      input  o_req_ready, o_rsp_valid, o_rsp_data, o_rsp_err,
      input  o_calc_sel, o_calc_a, o_calc_b, o_busy
   );

endinterface

// File: rtl/calc_arbiter_rr.sv
// Round-robin pick: first valid requester at or after ptr, wrapping to 0.
module calc_rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int PW      = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] valid,
   input  logic [PW-1:0]      ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [PW-1:0]      idx,
   output logic               any
);

   logic [PW-1:0] k;

   always_comb begin
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      k     = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         k = PW'((int'(ptr) + i) % NUM_REQ);
         if (!any && valid[k]) begin
            any      = 1'b1;
            grant[k] = 1'b1;
            idx      = k;
         end
      end
   end

endmodule

// File: rtl/calc_arbiter.sv
// Round-robin sharing of one calculator among NUM_REQ requesters.
// Optional CALC_ARB_DIVZERO_EN: DIV by zero answered directly with an error.
module calc_arbiter
   import calc_pkg::*;
#(
   parameter int NUM_REQ  = 4,
   parameter int CALC_LAT = 1
) (
   input logic           clk,
   input logic           rst_n,
   calc_arbiter_if.slave bus
);

   localparam int PW = $clog2(NUM_REQ);
   localparam logic [2:0] CNT_INIT = 3'(CALC_LAT);

   calc_arb_state_e       state;
   logic [PW-1:0]         ptr;
   logic [PW-1:0]         gidx;
   logic [PW-1:0]         g_q;
   logic [NUM_REQ-1:0]    grant;
   logic [NUM_REQ-1:0]    grant_q;
   logic                  any;
   logic [2:0]            cnt;
   calc_op_e              calc_sel;
   logic [CALC_IN_W-1:0]  calc_a;
   logic [CALC_IN_W-1:0]  calc_b;
   logic [NUM_REQ-1:0]    rsp_valid;
   logic [CALC_OUT_W-1:0] rsp_data;
   logic                  dz;

   logic [CALC_OP_W-1:0] sel_v [NUM_REQ];
   logic [CALC_IN_W-1:0] a_v   [NUM_REQ];
   logic [CALC_IN_W-1:0] b_v   [NUM_REQ];
   calc_op_e             req_sel;
   logic [CALC_IN_W-1:0] req_a;
   logic [CALC_IN_W-1:0] req_b;

   for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
      assign sel_v[k] = bus.i_req_sel[CALC_OP_W*k +: CALC_OP_W];
      assign a_v[k]   = bus.i_req_a[CALC_IN_W*k +: CALC_IN_W];
      assign b_v[k]   = bus.i_req_b[CALC_IN_W*k +: CALC_IN_W];
   end

   calc_rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .PW      (PW)
   ) u_rr (
      .valid (bus.i_req_valid),
      .ptr   (ptr),
      .grant (grant),
      .idx   (gidx),
      .any   (any)
   );

   assign req_sel = calc_op_e'(sel_v[gidx]);
   assign req_a   = a_v[gidx];
   assign req_b   = b_v[gidx];

   // accept strobe is only offered while idle and out of reset
   assign bus.o_req_ready = (rst_n && state == IDLE) ? grant : '0;
   assign bus.o_busy      = (state != IDLE);
   assign bus.o_calc_sel  = calc_sel;
   assign bus.o_calc_a    = calc_a;
   assign bus.o_calc_b    = calc_b;
   assign bus.o_rsp_valid = rsp_valid;
   assign bus.o_rsp_data  = rsp_data;

`ifdef CALC_ARB_DIVZERO_EN
   logic rsp_err;

   assign dz = (req_sel == DIV) && (req_b == '0);
   assign bus.o_rsp_err = rsp_err;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_err <= 1'b0;
      end else if (state == IDLE && any) begin
         rsp_err <= dz;
      end
   end
`else
   assign dz = 1'b0;
   assign bus.o_rsp_err = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         ptr       <= '0;
         g_q       <= '0;
         grant_q   <= '0;
         cnt       <= '0;
         calc_sel  <= SUM;
         calc_a    <= '0;
         calc_b    <= '0;
         rsp_valid <= '0;
         rsp_data  <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (any) begin
                  g_q     <= gidx;
                  grant_q <= grant;
                  if (dz) begin
                     state     <= RESP;
                     rsp_valid <= grant;
                     rsp_data  <= '1;
                  end else begin
                     state    <= EXEC;
                     cnt      <= CNT_INIT;
                     calc_sel <= req_sel;
                     calc_a   <= req_a;
                     calc_b   <= req_b;
                  end
               end
            end
            EXEC: begin
               if (cnt == '0) begin
                  state     <= RESP;
                  rsp_data  <= bus.i_calc_r;
                  rsp_valid <= grant_q;
               end else begin
                  cnt <= cnt - 3'd1;
               end
            end
            RESP: begin
               if (bus.i_rsp_ready[g_q]) begin
                  state     <= IDLE;
                  rsp_valid <= '0;
                  ptr <= (g_q == PW'(NUM_REQ-1)) ? '0 : g_q + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_calc_arbiter.sv
// Scoreboard bench for calc_arbiter with a behavioural registered calculator.
module tb_calc_arbiter;
   import calc_pkg::*;

   localparam int NUM_REQ  = 4;
   localparam int CALC_LAT = 1;

   typedef struct {
      int          id;
      logic [31:0] data;
      logic        err;
      int          lat;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   cyc   = 0;
   int   checks = 0;
   int   errors = 0;
   logic [15:0] last_b;
   exp_t sbq[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   calc_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

   calc_arbiter #(
      .NUM_REQ  (NUM_REQ),
      .CALC_LAT (CALC_LAT)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   function automatic logic [31:0] calc_f(logic [1:0] s, logic [15:0] a,
                                          logic [15:0] b);
      case (s)
         2'd0:    return 32'(a) + 32'(b);
         2'd1:    return {16'h0, 16'(a - b)};
         2'd2:    return 32'(a) * 32'(b);
         default: return (b == 16'd0) ? 32'd0 : 32'(a / b);
      endcase
   endfunction

   logic [31:0] cpipe [CALC_LAT];
   always @(posedge clk) begin
      cpipe[0] <= calc_f(bus.o_calc_sel, bus.o_calc_a, bus.o_calc_b);
      for (int i = 1; i < CALC_LAT; i++) cpipe[i] <= cpipe[i-1];
   end
   assign bus.i_calc_r = cpipe[CALC_LAT-1];

   function automatic logic [87:0] outs();
      return {bus.o_busy, bus.o_rsp_valid, bus.o_req_ready, bus.o_rsp_err,
              bus.o_calc_sel, bus.o_calc_a, bus.o_calc_b, bus.o_rsp_data};
   endfunction

   task automatic set_req(int k, logic [1:0] s, logic [15:0] a, logic [15:0] b);
      bus.i_req_sel[2*k +: 2] = s;
      bus.i_req_a[16*k +: 16] = a;
      bus.i_req_b[16*k +: 16] = b;
      bus.i_req_valid[k]      = 1'b1;
   endtask

   task automatic wait_ready(output int idx, output int t);
      idx = -1;
      t   = -1;
      for (int n = 0; n < 40 && idx < 0; n++) begin
         #1;
         for (int k = 0; k < NUM_REQ; k++)
            if (bus.o_req_ready[k]) idx = k;
         if (idx >= 0) t = cyc;
         else @(negedge clk);
      end
   endtask

   task automatic wait_valid(input logic [NUM_REQ-1:0] clr, output int lat);
      lat = -1;
      for (int n = 1; n <= 40 && lat < 0; n++) begin
         @(negedge clk);
         if (bus.o_rsp_valid != '0) lat = n;
         if (n == 1) bus.i_req_valid = bus.i_req_valid & ~clr;
      end
   endtask

   task automatic test_reset();
      int idx, t;
      logic seen;
      bus.i_req_valid = '0;
      bus.i_req_sel   = '0;
      bus.i_req_a     = '0;
      bus.i_req_b     = '0;
      bus.i_rsp_ready = '0;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (outs() !== '0) begin
         errors++;
         $display("FAIL reset_outs: got %h want 0", outs());
      end
      rst_n = 1'b1;
      @(negedge clk);
      set_req(0, MUL, 16'd7, 16'd7);
      wait_ready(idx, t);
      checks++;
      if (idx !== 0) begin
         errors++;
         $display("FAIL reset_grant: got %0d want 0", idx);
      end
      @(negedge clk);
      bus.i_req_valid = '0;
      checks++;
      if ({bus.o_busy, bus.o_calc_a} !== {1'b1, 16'd7}) begin
         errors++;
         $display("FAIL exec_state: got %h want 10007",
                  {bus.o_busy, bus.o_calc_a});
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (outs() !== '0) begin
         errors++;
         $display("FAIL reset_async: got %h want 0", outs());
      end
      @(negedge clk);
      rst_n = 1'b1;
      seen  = 1'b0;
      repeat (10) begin
         @(negedge clk);
         seen = seen | (|bus.o_rsp_valid) | bus.o_busy;
      end
      checks++;
      if (seen !== 1'b0) begin
         errors++;
         $display("FAIL reset_discard: got %b want 0", seen);
      end
   endtask

   task automatic test_single();
      int idx, t, lat;
      exp_t e;
      sbq.push_back('{0, 32'd7, 1'b0, CALC_LAT + 2});
      set_req(0, SUM, 16'd3, 16'd4);
      wait_ready(idx, t);
      e = sbq.pop_front();
      checks++;
      if (idx !== e.id) begin
         errors++;
         $display("FAIL single_grant: got %0d want %0d", idx, e.id);
      end
      wait_valid(4'b0001, lat);
      checks++;
      if (lat !== e.lat) begin
         errors++;
         $display("FAIL single_lat: got %0d want %0d", lat, e.lat);
      end
      checks++;
      if ({bus.o_rsp_valid, bus.o_rsp_data, bus.o_rsp_err} !==
          {4'(1 << e.id), e.data, e.err}) begin
         errors++;
         $display("FAIL single_rsp: got v=%b d=%h e=%b want d=%h e=%b",
                  bus.o_rsp_valid, bus.o_rsp_data, bus.o_rsp_err,
                  e.data, e.err);
      end
      bus.i_rsp_ready = 4'b0001;
      @(negedge clk);
      bus.i_rsp_ready = '0;
      checks++;
      if ({bus.o_rsp_valid, bus.o_busy} !== 5'b0) begin
         errors++;
         $display("FAIL single_done: got %b want 0",
                  {bus.o_rsp_valid, bus.o_busy});
      end
   endtask

   task automatic test_round_robin();
      int idx, t, lat, prev;
      exp_t e;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      for (int k = 0; k < NUM_REQ; k++)
         set_req(k, MUL, 16'(k + 1), 16'd2);
      for (int n = 0; n < 5; n++) begin
         int id = n % NUM_REQ;
         sbq.push_back('{id, 32'((id + 1) * 2), 1'b0, CALC_LAT + 2});
      end
      prev = -1;
      for (int n = 0; n < 5; n++) begin
         e = sbq.pop_front();
         wait_ready(idx, t);
         bus.i_rsp_ready = '0;
         checks++;
         if (idx !== e.id) begin
            errors++;
            $display("FAIL rr_grant%0d: got %0d want %0d", n, idx, e.id);
         end
         if (prev >= 0) begin
            checks++;
            if (t - prev !== CALC_LAT + 3) begin
               errors++;
               $display("FAIL rr_gap%0d: got %0d want %0d",
                        n, t - prev, CALC_LAT + 3);
            end
         end
         prev = t;
         wait_valid('0, lat);
         checks++;
         if ({lat, bus.o_rsp_valid, bus.o_rsp_data} !==
             {e.lat, 4'(1 << e.id), e.data}) begin
            errors++;
            $display("FAIL rr_rsp%0d: got l=%0d v=%b d=%h want l=%0d d=%h",
                     n, lat, bus.o_rsp_valid, bus.o_rsp_data, e.lat, e.data);
         end
         bus.i_rsp_ready[e.id] = 1'b1;
         if (n == 4) bus.i_req_valid = '0;
      end
      @(negedge clk);
      bus.i_rsp_ready = '0;
   endtask

   task automatic test_backpressure();
      int idx, t, lat;
      exp_t e;
      sbq.push_back('{1, 32'd14, 1'b0, CALC_LAT + 2});
      set_req(1, DIV, 16'd100, 16'd7);
      wait_ready(idx, t);
      e = sbq.pop_front();
      checks++;
      if (idx !== e.id) begin
         errors++;
         $display("FAIL bp_grant: got %0d want %0d", idx, e.id);
      end
      wait_valid(4'b0010, lat);
      bus.i_rsp_ready = 4'b1101;
      for (int n = 0; n < 5; n++) begin
         @(negedge clk);
         checks++;
         if ({bus.o_rsp_valid, bus.o_rsp_data} !== {4'b0010, e.data}) begin
            errors++;
            $display("FAIL bp_hold%0d: got v=%b d=%h want v=0010 d=%h",
                     n, bus.o_rsp_valid, bus.o_rsp_data, e.data);
         end
      end
      bus.i_rsp_ready = 4'b0010;
      @(negedge clk);
      bus.i_rsp_ready = '0;
      checks++;
      if (bus.o_rsp_valid !== '0) begin
         errors++;
         $display("FAIL bp_release: got %b want 0", bus.o_rsp_valid);
      end
   endtask

   task automatic test_wrap();
      int idx, t, lat;
      exp_t e;
      // req2 op first moves the pointer to 3
      sbq.push_back('{2, 32'd2, 1'b0, CALC_LAT + 2});
      sbq.push_back('{1, 32'h0000_FFFC, 1'b0, CALC_LAT + 2});
      sbq.push_back('{2, 32'd2, 1'b0, CALC_LAT + 2});
      set_req(2, SUM, 16'd1, 16'd1);
      for (int n = 0; n < 3; n++) begin
         if (n == 1) begin
            set_req(1, SUB, 16'd5, 16'd9);
            set_req(2, SUM, 16'd1, 16'd1);
         end
         e = sbq.pop_front();
         wait_ready(idx, t);
         bus.i_rsp_ready = '0;
         checks++;
         if (idx !== e.id) begin
            errors++;
            $display("FAIL wrap_grant%0d: got %0d want %0d", n, idx, e.id);
         end
         wait_valid(4'(1 << e.id), lat);
         checks++;
         if ({bus.o_rsp_valid, bus.o_rsp_data} !== {4'(1 << e.id), e.data})
         begin
            errors++;
            $display("FAIL wrap_rsp%0d: got v=%b d=%h want d=%h",
                     n, bus.o_rsp_valid, bus.o_rsp_data, e.data);
         end
         bus.i_rsp_ready[e.id] = 1'b1;
      end
      last_b = 16'd1;
      @(negedge clk);
      bus.i_rsp_ready = '0;
   endtask

   task automatic test_divzero();
      int idx, t, lat;
      exp_t e;
`ifdef CALC_ARB_DIVZERO_EN
      sbq.push_back('{2, 32'hFFFF_FFFF, 1'b1, 1});
`else
      sbq.push_back('{2, 32'd0, 1'b0, CALC_LAT + 2});
`endif
      set_req(2, DIV, 16'd9, 16'd0);
      wait_ready(idx, t);
      e = sbq.pop_front();
      checks++;
      if (idx !== e.id) begin
         errors++;
         $display("FAIL dz_grant: got %0d want %0d", idx, e.id);
      end
      wait_valid(4'b0100, lat);
      checks++;
      if (lat !== e.lat) begin
         errors++;
         $display("FAIL dz_lat: got %0d want %0d", lat, e.lat);
      end
      checks++;
      if ({bus.o_rsp_valid, bus.o_rsp_data, bus.o_rsp_err} !==
          {4'b0100, e.data, e.err}) begin
         errors++;
         $display("FAIL dz_rsp: got v=%b d=%h e=%b want d=%h e=%b",
                  bus.o_rsp_valid, bus.o_rsp_data, bus.o_rsp_err,
                  e.data, e.err);
      end
`ifdef CALC_ARB_DIVZERO_EN
      checks++;
      if (bus.o_calc_b !== last_b) begin
         errors++;
         $display("FAIL dz_operands: got %h want %h", bus.o_calc_b, last_b);
      end
`endif
      bus.i_rsp_ready = 4'b0100;
      @(negedge clk);
      bus.i_rsp_ready = '0;
      checks++;
      if ({bus.o_rsp_valid, bus.o_busy} !== 5'b0) begin
         errors++;
         $display("FAIL dz_done: got %b want 0",
                  {bus.o_rsp_valid, bus.o_busy});
      end
   endtask

   initial begin
      last_b = 16'd0;
      test_reset();
      test_single();
      test_round_robin();
      test_backpressure();
      test_wrap();
      test_divzero();
      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog");
   end

endmodule
